sb_rx_decode_ctrl: RTL and testbench

//  Parametrised sideband RX decode controller; next generation of the SB RX FSM. Receives deserialised words.

---
 rtl/sb_rx_pkg.sv | 38 +++
 rtl/sb_rx_lock_tracker.sv | 42 ++++
 rtl/sb_rx_decode_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sb_rx_decode_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_rx_pkg.sv
// rtl/sb_rx_pkg.sv - shared state type, field positions and word classifiers for the SB RX decoder
package sb_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOCK,
      ST_GEN,
      ST_RDI,
      ST_HDR,
      ST_DATA,
      ST_ADPT
   } e_sb_rx_state;

   localparam int OPC_LSB = 0;
   localparam int OPC_MSB = 4;
   localparam int SUB_LSB = 14;
   localparam int SUB_MSB = 17;
   localparam int MSG_LSB = 18;
   localparam int MSG_MSB = 21;
   localparam int DST_LSB = 56;
   localparam int DST_MSB = 58;
   localparam int CP_BIT  = 62;
   localparam int DP_BIT  = 63;

   localparam logic [63:0] SB_PATTERN   = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [4:0]  OPC_MSG_DATA = 5'b11011;
   localparam logic [3:0]  SUBCODE_RSP  = 4'hA;

   function automatic logic is_pattern(input logic [63:0] w);
      return w == SB_PATTERN;
   endfunction

   // cp makes the whole header below dp even parity
   function automatic logic hdr_parity_ok(input logic [63:0] w);
      return (^w[CP_BIT:0]) == 1'b0;
   endfunction

endpackage

// File: rtl/sb_rx_lock_tracker.sv
// rtl/sb_rx_lock_tracker.sv - consecutive pattern counter and inter-word lock timer
module sb_rx_lock_tracker #(
   parameter int PATTERN_REPS = 2,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic locking,
   input  logic word_valid,
   input  logic pattern,
   output logic lock_hit,
   output logic timeout_hit
);

   localparam int CNT_W = $clog2(PATTERN_REPS + 1);
   localparam int TMR_W = $clog2(LOCK_TIMEOUT + 2);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;
   logic [TMR_W-1:0] elapsed;

   assign count_inc   = idle ? CNT_W'(1) : count + CNT_W'(1);
   assign lock_hit    = word_valid && pattern && (idle || locking) &&
                        (count_inc == CNT_W'(PATTERN_REPS));
   // elapsed counts silent cycles since the last word; the word cycle itself is not silence
   assign timeout_hit = (LOCK_TIMEOUT != 0) && locking && !word_valid &&
                        (elapsed == TMR_W'(LOCK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || !(idle || locking)) begin
         count   <= '0;
         elapsed <= '0;
      end else if (word_valid) begin
         elapsed <= '0;
         count   <= pattern ? count_inc : '0;
      end else if (locking && elapsed != TMR_W'(LOCK_TIMEOUT)) begin
         elapsed <= elapsed + TMR_W'(1);
      end
   end

endmodule

// File: rtl/sb_rx_decode_ctrl.sv
// rtl/sb_rx_decode_ctrl.sv - sideband RX decode controller: pattern lock, word classification, decoder steering
module sb_rx_decode_ctrl
   import sb_rx_pkg::*;
#(
   parameter int WORD_W       = 64,
   parameter int PATTERN_REPS = 2,
   parameter int LOCK_TIMEOUT = 255,
   parameter int DATA_BEATS   = 1,
   parameter int ERR_CNT_W    = 8,
   parameter int ADAPTER_EN   = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_word_valid,
   input  logic [WORD_W-1:0]    i_word,
   input  logic [3:0]           i_state,
   input  logic                 i_hdr_done,
   input  logic                 i_rdi_done,
   input  logic                 i_data_done,
   output logic                 o_start_pattern,
   output logic                 o_pattern_done,
   output logic                 o_locked,
   output logic                 o_lock_timeout,
   output logic                 o_hdr_en,
   output logic                 o_rdi_en,
   output logic                 o_data_en,
   output logic [3:0]           o_beat_idx,
   output logic                 o_adapter_en,
   output logic                 o_msg_valid,
   output logic                 o_rsp_delivered,
   output logic                 o_parity_err,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   e_sb_rx_state      state;
   logic [WORD_W-1:0] pend_word;
   logic              pend_valid;
   logic [WORD_W-1:0] word;
   logic              word_valid;
   logic [63:0]       w64;
   logic              pattern;
   logic              hdr_ok;
   logic              data_ok;
   logic              done_fire;
   logic              abort;
   logic              lock_hit;
   logic              timeout_hit;
   logic              dp_q;
   logic [4:0]        opcode_q;
   logic [3:0]        beat;

   // a word that arrives with a done is parked one cycle and evaluated in the next state
   assign word       = pend_valid ? pend_word : i_word;
   assign word_valid = pend_valid | i_word_valid;
   assign w64        = word[63:0];
   assign pattern    = is_pattern(w64);
   assign hdr_ok     = hdr_parity_ok(w64);
   assign data_ok    = (^{word, dp_q}) == 1'b0;
   assign abort      = (state != ST_IDLE) && (state != ST_LOCK) && (i_state == 4'd0);

   always_comb begin
      done_fire = 1'b0;
      case (state)
         ST_RDI:  done_fire = i_rdi_done;
         ST_HDR:  done_fire = i_hdr_done;
         ST_DATA: done_fire = i_data_done;
         default: done_fire = 1'b0;
      endcase
   end

   sb_rx_lock_tracker #(
      .PATTERN_REPS (PATTERN_REPS),
      .LOCK_TIMEOUT (LOCK_TIMEOUT)
   ) u_lock (
      .clk         (i_clk),
      .rst         (i_rst),
      .idle        (state == ST_IDLE),
      .locking     (state == ST_LOCK),
      .word_valid  (word_valid),
      .pattern     (pattern),
      .lock_hit    (lock_hit),
      .timeout_hit (timeout_hit)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst || abort) begin
         pend_valid <= 1'b0;
         pend_word  <= '0;
      end else if (done_fire && word_valid) begin
         pend_valid <= 1'b1;
         pend_word  <= word;
      end else if (pend_valid && i_word_valid) begin
         pend_valid <= 1'b1;
         pend_word  <= i_word;
      end else begin
         pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= ST_IDLE;
         dp_q            <= 1'b0;
         opcode_q        <= '0;
         beat            <= '0;
         o_start_pattern <= 1'b0;
         o_pattern_done  <= 1'b0;
         o_locked        <= 1'b0;
         o_lock_timeout  <= 1'b0;
         o_hdr_en        <= 1'b0;
         o_rdi_en        <= 1'b0;
         o_data_en       <= 1'b0;
         o_beat_idx      <= '0;
         o_adapter_en    <= 1'b0;
         o_msg_valid     <= 1'b0;
         o_rsp_delivered <= 1'b0;
         o_parity_err    <= 1'b0;
         o_err_cnt       <= '0;
      end else begin
         o_start_pattern <= 1'b0;
         o_pattern_done  <= 1'b0;
         o_lock_timeout  <= 1'b0;
         o_hdr_en        <= 1'b0;
         o_rdi_en        <= 1'b0;
         o_data_en       <= 1'b0;
         o_adapter_en    <= 1'b0;
         o_msg_valid     <= 1'b0;
         o_rsp_delivered <= 1'b0;
         o_parity_err    <= 1'b0;
         if (abort) begin
            state    <= ST_IDLE;
            o_locked <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (word_valid && pattern) begin
                     o_start_pattern <= (i_state == 4'd0);
                     if (lock_hit) begin
                        state          <= ST_GEN;
                        o_pattern_done <= 1'b1;
                        o_locked       <= 1'b1;
                     end else begin
                        state <= ST_LOCK;
                     end
                  end
               end
               ST_LOCK: begin
                  if (lock_hit) begin
                     state          <= ST_GEN;
                     o_pattern_done <= 1'b1;
                     o_locked       <= 1'b1;
                  end else if (timeout_hit) begin
                     state          <= ST_IDLE;
                     o_lock_timeout <= 1'b1;
                  end
               end
               ST_GEN: begin
                  if (word_valid && !pattern) begin
                     if (w64[DST_LSB] && ADAPTER_EN != 0) begin
                        state <= ST_ADPT;
                     end else if (!hdr_ok) begin
                        o_parity_err <= 1'b1;
                        if (o_err_cnt != {ERR_CNT_W{1'b1}})
                           o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
                     end else if (w64[MSG_MSB:MSG_LSB] == 4'd0) begin
                        state    <= ST_RDI;
                        o_rdi_en <= 1'b1;
                     end else begin
                        state           <= ST_HDR;
                        o_hdr_en        <= 1'b1;
                        dp_q            <= w64[DP_BIT];
                        opcode_q        <= w64[OPC_MSB:OPC_LSB];
                        o_rsp_delivered <= (w64[SUB_MSB:SUB_LSB] == SUBCODE_RSP);
                     end
                  end
               end
               ST_ADPT: begin
                  o_adapter_en <= 1'b1;
                  state        <= ST_GEN;
               end
               ST_RDI: begin
                  if (i_rdi_done) begin
                     state       <= ST_GEN;
                     o_msg_valid <= 1'b1;
                  end
               end
               ST_HDR: begin
                  if (i_hdr_done) begin
                     if (opcode_q == OPC_MSG_DATA) begin
                        state <= ST_DATA;
                        beat  <= '0;
                     end else begin
                        state       <= ST_GEN;
                        o_msg_valid <= 1'b1;
                     end
                  end
               end
               ST_DATA: begin
                  if (i_data_done) begin
                     if (beat == 4'(DATA_BEATS - 1)) begin
                        state       <= ST_GEN;
                        o_msg_valid <= 1'b1;
                     end
                     beat <= beat + 4'd1;
                  end else if (word_valid) begin
                     if (data_ok) begin
                        o_data_en  <= 1'b1;
                        o_beat_idx <= beat;
                     end else begin
                        state        <= ST_GEN;
                        o_parity_err <= 1'b1;
                        if (o_err_cnt != {ERR_CNT_W{1'b1}})
                           o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sb_rx_decode_ctrl.sv
// tb/tb_sb_rx_decode_ctrl.sv - randomized scoreboard bench for sb_rx_decode_ctrl
module tb_sb_rx_decode_ctrl;

   localparam int WORD_W       = 64;
   localparam int PATTERN_REPS = 2;
   localparam int LOCK_TIMEOUT = 8;
   localparam int DATA_BEATS   = 3;
   localparam int ERR_CNT_W    = 8;
   localparam int ADAPTER_EN   = 1;
   localparam logic [63:0] PAT      = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [4:0]  OPC_DATA = 5'b11011;

   // bit positions of the pulse outputs in the monitored vector
   localparam int B_START = 9, B_PDONE = 8, B_TMO = 7, B_HDR = 6, B_RDI = 5;
   localparam int B_DATA = 4, B_ADPT = 3, B_MSG = 2, B_RSP = 1, B_PERR = 0;
   localparam int D_RDI = 0, D_HDR = 1, D_DATA = 2;

   logic                 clk = 1'b0;
   logic                 i_rst = 1'b1;
   logic                 i_word_valid = 1'b0;
   logic [WORD_W-1:0]    i_word = '0;
   logic [3:0]           i_state = 4'd0;
   logic                 i_hdr_done = 1'b0;
   logic                 i_rdi_done = 1'b0;
   logic                 i_data_done = 1'b0;
   logic                 o_start_pattern, o_pattern_done, o_locked, o_lock_timeout;
   logic                 o_hdr_en, o_rdi_en, o_data_en, o_adapter_en;
   logic                 o_msg_valid, o_rsp_delivered, o_parity_err;
   logic [3:0]           o_beat_idx;
   logic [ERR_CNT_W-1:0] o_err_cnt;

   typedef struct {
      int         cyc;
      logic [9:0] bits;
      logic [3:0] beat;
      logic [7:0] err;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   logic [9:0] mon_p;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         m_err = 0;

   sb_rx_decode_ctrl #(
      .WORD_W(WORD_W), .PATTERN_REPS(PATTERN_REPS), .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .DATA_BEATS(DATA_BEATS), .ERR_CNT_W(ERR_CNT_W), .ADAPTER_EN(ADAPTER_EN)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_word_valid(i_word_valid), .i_word(i_word),
      .i_state(i_state), .i_hdr_done(i_hdr_done), .i_rdi_done(i_rdi_done),
      .i_data_done(i_data_done), .o_start_pattern(o_start_pattern),
      .o_pattern_done(o_pattern_done), .o_locked(o_locked), .o_lock_timeout(o_lock_timeout),
      .o_hdr_en(o_hdr_en), .o_rdi_en(o_rdi_en), .o_data_en(o_data_en),
      .o_beat_idx(o_beat_idx), .o_adapter_en(o_adapter_en), .o_msg_valid(o_msg_valid),
      .o_rsp_delivered(o_rsp_delivered), .o_parity_err(o_parity_err), .o_err_cnt(o_err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [9:0] bit_of(input int b);
      logic [9:0] one;
      one = 10'd1;
      return one << b;
   endfunction

   task automatic expect_ev(input int c, input logic [9:0] bits, input logic [3:0] beat);
      exp_t e;
      e.cyc  = c;
      e.bits = bits;
      e.beat = beat;
      e.err  = 8'((m_err > 255) ? 255 : m_err);
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!i_rst) begin
         mon_p = {o_start_pattern, o_pattern_done, o_lock_timeout, o_hdr_en, o_rdi_en,
                  o_data_en, o_adapter_en, o_msg_valid, o_rsp_delivered, o_parity_err};
         if (mon_p != 10'd0) begin
            if (q.size() == 0) begin
               check("unexpected_pulse", 64'(mon_p), 64'd0);
            end else begin
               mon_e = q.pop_front();
               check("event_cycle", 64'(cyc), 64'(mon_e.cyc));
               check("event_pulses", 64'(mon_p), 64'(mon_e.bits));
               if (mon_e.bits[B_DATA]) check("beat_idx", 64'(o_beat_idx), 64'(mon_e.beat));
               check("err_cnt", 64'(o_err_cnt), 64'(mon_e.err));
            end
         end
      end
   end

   function automatic logic [63:0] mk_hdr(input logic [3:0] msg, input logic [3:0] sub,
                                          input logic [4:0] opc, input logic [2:0] dst,
                                          input bit good);
      logic [63:0] w;
      w = {$urandom, $urandom};
      w[4:0]   = opc;
      w[17:14] = sub;
      w[21:18] = msg;
      w[58:56] = dst;
      w[62]    = (^w[61:0]) ^ (good ? 1'b0 : 1'b1);
      return w;
   endfunction

   function automatic logic [63:0] mk_data(input logic dp, input bit good);
      logic [63:0] w;
      w    = {$urandom, $urandom};
      w[0] = 1'b0;
      w[0] = (^w) ^ dp ^ (good ? 1'b0 : 1'b1);
      return w;
   endfunction

   function automatic logic [2:0] rnd_dst_local();
      logic [2:0] d;
      d = 3'($urandom_range(0, 7));
      return d & 3'b110;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gap();
      step($urandom_range(0, 3));
   endtask

   task automatic send(input logic [63:0] w, output int k);
      i_word       = w;
      i_word_valid = 1'b1;
      @(posedge clk);
      #1;
      k            = cyc;
      i_word_valid = 1'b0;
   endtask

   task automatic done_pulse(input int which, output int k);
      i_rdi_done  = (which == D_RDI);
      i_hdr_done  = (which == D_HDR);
      i_data_done = (which == D_DATA);
      @(posedge clk);
      #1;
      k           = cyc;
      i_rdi_done  = 1'b0;
      i_hdr_done  = 1'b0;
      i_data_done = 1'b0;
   endtask

   task automatic do_lock(input bit with_noise);
      int k;
      i_state = 4'd0;
      send(PAT, k);
      expect_ev(k, bit_of(B_START), 4'd0);
      step(3);
      if (with_noise) begin
         send({$urandom, $urandom} | 64'd1, k);
         step(1);
         send(PAT, k);
         step(1);
      end
      i_state = 4'd3;
      send(PAT, k);
      expect_ev(k, bit_of(B_PDONE), 4'd0);
      step(1);
      check("locked_after_lock", 64'(o_locked), 64'd1);
   endtask

   task automatic msg_hdr(input logic [3:0] msg, input logic [3:0] sub, input logic [4:0] opc);
      int k;
      logic [63:0] w;
      logic [9:0] bits;
      w = mk_hdr(msg, sub, opc, rnd_dst_local(), 1'b1);
      send(w, k);
      bits = bit_of(B_HDR) | ((sub == 4'hA) ? bit_of(B_RSP) : 10'd0);
      expect_ev(k, bits, 4'd0);
      gap();
      done_pulse(D_HDR, k);
      if (opc != OPC_DATA) begin
         expect_ev(k, bit_of(B_MSG), 4'd0);
      end else begin
         for (int b = 0; b < DATA_BEATS; b++) begin
            gap();
            send(mk_data(w[63], 1'b1), k);
            expect_ev(k, bit_of(B_DATA), 4'(b));
            gap();
            done_pulse(D_DATA, k);
            if (b == DATA_BEATS - 1) expect_ev(k, bit_of(B_MSG), 4'd0);
         end
      end
      gap();
   endtask

   task automatic msg_rdi();
      int k;
      send(mk_hdr(4'd0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), rnd_dst_local(), 1'b1), k);
      expect_ev(k, bit_of(B_RDI), 4'd0);
      gap();
      done_pulse(D_RDI, k);
      expect_ev(k, bit_of(B_MSG), 4'd0);
      gap();
   endtask

   task automatic msg_adapter();
      int k;
      logic [2:0] dst;
      dst = 3'($urandom_range(0, 7)) | 3'b001;
      send(mk_hdr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)), dst, 1'($urandom_range(0, 1))), k);
      expect_ev(k + 1, bit_of(B_ADPT), 4'd0);
      step(1);
      gap();
   endtask

   task automatic bad_hdr();
      int k;
      send(mk_hdr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  5'($urandom_range(0, 31)), rnd_dst_local(), 1'b0), k);
      m_err++;
      expect_ev(k, bit_of(B_PERR), 4'd0);
   endtask

   task automatic random_msg();
      int k;
      logic [4:0] opc;
      case ($urandom_range(0, 5))
         0: begin
            send(PAT, k);
            gap();
         end
         1: msg_rdi();
         2: begin
            opc = 5'($urandom_range(0, 31));
            if (opc == OPC_DATA) opc = 5'b10010;
            msg_hdr(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), opc);
         end
         3: msg_hdr(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), OPC_DATA);
         4: msg_adapter();
         default: begin
            bad_hdr();
            gap();
         end
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int k;
      logic [63:0] w;

      step(3);
      check("reset_locked", 64'(o_locked), 64'd0);
      check("reset_err_cnt", 64'(o_err_cnt), 64'd0);
      check("reset_beat_idx", 64'(o_beat_idx), 64'd0);
      check("reset_pulses", 64'({o_start_pattern, o_pattern_done, o_lock_timeout, o_hdr_en,
                                 o_rdi_en, o_data_en, o_adapter_en, o_msg_valid,
                                 o_rsp_delivered, o_parity_err}), 64'd0);
      i_rst = 1'b0;
      step(2);

      do_lock(1'b0);
      msg_hdr(4'd1, 4'hA, 5'b10010);
      msg_rdi();
      msg_hdr(4'd5, 4'd3, OPC_DATA);
      msg_adapter();

      // done and next header in the same cycle
      send(mk_hdr(4'd1, 4'd0, 5'b00001, 3'b000, 1'b1), k);
      expect_ev(k, bit_of(B_HDR), 4'd0);
      step(1);
      i_hdr_done   = 1'b1;
      i_word       = mk_hdr(4'd2, 4'hA, 5'b00011, 3'b000, 1'b1);
      i_word_valid = 1'b1;
      step(1);
      k            = cyc;
      i_hdr_done   = 1'b0;
      i_word_valid = 1'b0;
      expect_ev(k, bit_of(B_MSG), 4'd0);
      expect_ev(k + 1, bit_of(B_HDR) | bit_of(B_RSP), 4'd0);
      step(2);
      done_pulse(D_HDR, k);
      expect_ev(k, bit_of(B_MSG), 4'd0);
      step(1);

      // bad data parity aborts the message
      w = mk_hdr(4'd3, 4'd0, OPC_DATA, 3'b000, 1'b1);
      send(w, k);
      expect_ev(k, bit_of(B_HDR), 4'd0);
      done_pulse(D_HDR, k);
      send(mk_data(w[63], 1'b1), k);
      expect_ev(k, bit_of(B_DATA), 4'd0);
      done_pulse(D_DATA, k);
      send(mk_data(w[63], 1'b0), k);
      m_err++;
      expect_ev(k, bit_of(B_PERR), 4'd0);
      step(1);
      msg_hdr(4'd1, 4'hA, 5'b10010);

      repeat (40) random_msg();

      // LTSM reset from GEN, then lock timeout
      i_state = 4'd0;
      step(1);
      check("locked_after_gen_abort", 64'(o_locked), 64'd0);
      step(2);
      send(PAT, k);
      expect_ev(k, bit_of(B_START), 4'd0);
      expect_ev(k + LOCK_TIMEOUT, bit_of(B_TMO), 4'd0);
      step(LOCK_TIMEOUT + 3);
      check("locked_after_timeout", 64'(o_locked), 64'd0);
      do_lock(1'b1);

      // LTSM reset during DATA overrides a bad-parity word
      w = mk_hdr(4'd7, 4'd1, OPC_DATA, 3'b000, 1'b1);
      send(w, k);
      expect_ev(k, bit_of(B_HDR), 4'd0);
      done_pulse(D_HDR, k);
      send(mk_data(w[63], 1'b1), k);
      expect_ev(k, bit_of(B_DATA), 4'd0);
      i_state      = 4'd0;
      i_word       = mk_data(w[63], 1'b0);
      i_word_valid = 1'b1;
      step(1);
      i_word_valid = 1'b0;
      check("locked_after_data_abort", 64'(o_locked), 64'd0);
      step(3);
      do_lock(1'b0);

      for (int i = 0; i < 300; i++) bad_hdr();
      step(2);
      check("err_cnt_saturated", 64'(o_err_cnt), 64'd255);

      // reset in the middle of a data message
      w = mk_hdr(4'd2, 4'd0, OPC_DATA, 3'b000, 1'b1);
      send(w, k);
      expect_ev(k, bit_of(B_HDR), 4'd0);
      done_pulse(D_HDR, k);
      step(1);
      i_rst = 1'b1;
      step(1);
      m_err = 0;
      check("midreset_err_cnt", 64'(o_err_cnt), 64'd0);
      check("midreset_locked", 64'(o_locked), 64'd0);
      i_rst = 1'b0;
      step(2);
      do_lock(1'b0);
      msg_hdr(4'd9, 4'hA, OPC_DATA);

      step(5);
      check("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
